// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command controller.
package alu_cmd_ctrl_pkg;

  localparam int          DATA_W_DEF     = 8;
  localparam logic [7:0]  CMD_OPER_DEF   = 8'hCC;
  localparam logic [7:0]  CMD_NOOPER_DEF = 8'hDD;
  localparam int          WAIT_MAX_DEF   = 4;

  // Function codes understood by the external ALU; 4'hF is reserved and yields 0.
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_MUL  = 4'h2;
  localparam logic [3:0] FN_DIV  = 4'h3;
  localparam logic [3:0] FN_AND  = 4'h4;
  localparam logic [3:0] FN_OR   = 4'h5;
  localparam logic [3:0] FN_NAND = 4'h6;
  localparam logic [3:0] FN_NOR  = 4'h7;
  localparam logic [3:0] FN_XOR  = 4'h8;
  localparam logic [3:0] FN_XNOR = 4'h9;
  localparam logic [3:0] FN_EQ   = 4'hA;
  localparam logic [3:0] FN_GT   = 4'hB;
  localparam logic [3:0] FN_LT   = 4'hC;
  localparam logic [3:0] FN_SHR  = 4'hD;
  localparam logic [3:0] FN_SHL  = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_ALU_REQ,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the system ALU: parses the RX byte stream,
// drives operands/function/enable, captures the result and streams it back
// LSB first on a valid/ready TX interface.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_W_DEF,
  parameter int                    OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER   = CMD_OPER_DEF,
  parameter logic [DATA_WIDTH-1:0] CMD_NOOPER = CMD_NOOPER_DEF,
  parameter int                    WAIT_MAX   = WAIT_MAX_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  RX_DROP,
  output logic                  ERR
);

  localparam int                CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t                         r_state;
  logic [CNT_W-1:0]               r_wait_cnt;
  // Only the upper result byte needs storing: the lower byte goes straight to TX_DATA.
  logic [OUT_WIDTH-DATA_WIDTH-1:0] r_res_hi;

  logic w_busy;
  assign w_busy = (r_state == ST_ALU_REQ) || (r_state == ST_ALU_WAIT) ||
                  (r_state == ST_TX_LO)   || (r_state == ST_TX_HI);

  // Command FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_res_hi   <= '0;
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      TX_DATA    <= '0;
      TX_VALID   <= 1'b0;
      RX_DROP    <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      ALU_EN  <= 1'b0;
      ERR     <= 1'b0;
      RX_DROP <= w_busy && RX_VALID;
      case (r_state)
        ST_IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == CMD_OPER)        r_state <= ST_GET_A;
            else if (RX_DATA == CMD_NOOPER) r_state <= ST_GET_FUN;
          end
        end
        ST_GET_A: begin
          if (RX_VALID) begin
            ALU_A   <= RX_DATA;
            r_state <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (RX_VALID) begin
            ALU_B   <= RX_DATA;
            r_state <= ST_GET_FUN;
          end
        end
        ST_GET_FUN: begin
          if (RX_VALID) begin
            ALU_FUN <= RX_DATA[3:0];
            ALU_EN  <= 1'b1;
            r_state <= ST_ALU_REQ;
          end
        end
        ST_ALU_REQ: begin
          r_wait_cnt <= '0;
          r_state    <= ST_ALU_WAIT;
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
            r_res_hi <= ALU_OUT[OUT_WIDTH-1:DATA_WIDTH];
            TX_VALID <= 1'b1;
            r_state  <= ST_TX_LO;
          end else if (r_wait_cnt == CNT_LAST) begin
            // WAIT_MAX wait cycles without a result: give up, send nothing.
            ERR     <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_TX_LO: begin
          if (TX_READY) begin
            TX_DATA <= r_res_hi;
            r_state <= ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          if (TX_READY) begin
            TX_VALID <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: registered ALU model, TX sink with READY stalls,
// vector table, hand-written corner sequences and randomized commands.
module tb_alu_cmd_ctrl;
  import alu_cmd_ctrl_pkg::*;

  localparam int WAIT_MAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        RX_DROP, ERR;

  alu_cmd_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DROP(RX_DROP), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // ALU function as a plain arithmetic table.
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'h0: return 16'(a) + 16'(b);
      4'h1: return 16'(a) - 16'(b);
      4'h2: return 16'(a) * 16'(b);
      4'h3: return (b == 0) ? 16'h0 : 16'(a / b);
      4'h4: return {8'h0, a & b};
      4'h5: return {8'h0, a | b};
      4'h6: return {8'h0, ~(a & b)};
      4'h7: return {8'h0, ~(a | b)};
      4'h8: return {8'h0, a ^ b};
      4'h9: return {8'h0, ~(a ^ b)};
      4'hA: return (a == b) ? 16'h1 : 16'h0;
      4'hB: return (a > b)  ? 16'h1 : 16'h0;
      4'hC: return (a < b)  ? 16'h1 : 16'h0;
      4'hD: return 16'(a >> 1);
      4'hE: return 16'(a) << 1;
      default: return 16'h0;
    endcase
  endfunction

  // External ALU model: result registered one cycle after ALU_EN; can be muted.
  logic mute = 1'b0;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_OUT       <= 16'h0;
      ALU_OUT_VALID <= 1'b0;
    end else begin
      ALU_OUT_VALID <= ALU_EN && !mute;
      if (ALU_EN) ALU_OUT <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end
  end

  // Enable pulse counter plus a sticky flag for any pulse wider than one cycle.
  int   en_cnt = 0;
  logic en_prev = 1'b0;
  logic en_wide = 1'b0;
  always @(negedge CLK) begin
    if (ALU_EN) en_cnt <= en_cnt + 1;
    if (ALU_EN && en_prev) en_wide <= 1'b1;
    en_prev <= ALU_EN;
  end

  // Reference state: what the controller should hold as operands/function.
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [3:0] m_fun = 4'h0;

  function automatic logic [15:0] model_cmd(input logic [7:0] cmd, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] fb);
    if (cmd == 8'hCC) begin
      m_a = a;
      m_b = b;
    end
    m_fun = fb[3:0];
    return alu_f(m_a, m_b, m_fun);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  task automatic send(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  // Wait for a TX byte, stall READY for 'stall' cycles checking it is held, then accept.
  task automatic get_byte(input int stall, output logic [7:0] d);
    int n = 0;
    while (!TX_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!TX_VALID) begin
      fail_to("tx_wait");
      d = 8'hxx;
      return;
    end
    d = TX_DATA;
    for (int k = 0; k < stall; k++) begin
      @(negedge CLK);
      chk("tx_hold_valid", 32'(TX_VALID), 32'd1);
      chk("tx_hold_data", 32'(TX_DATA), 32'(d));
    end
    TX_READY = 1'b1;
    @(negedge CLK);
    TX_READY = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fb, input int st_lo, input int st_hi,
                        output logic [7:0] lo, output logic [7:0] hi);
    send(cmd);
    if (cmd == 8'hCC) begin
      send(a);
      send(b);
    end
    send(fb);
    get_byte(st_lo, lo);
    get_byte(st_hi, hi);
  endtask

  typedef struct {
    logic [7:0] cmd, a, b, fb;
    int         stall;
    logic [7:0] ea, eb;
    logic [3:0] ef;
    logic [7:0] lo, hi;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0]  lo, hi, c, a, b, fb;
    logic [15:0] r;
    int          e0, n, err_at, err_n, tx_seen;

    tbl[0] = '{8'hCC, 8'h05, 8'h03, 8'h00, 0, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00};
    tbl[1] = '{8'hDD, 8'h00, 8'h00, 8'h02, 0, 8'h05, 8'h03, 4'h2, 8'h0F, 8'h00};
    tbl[2] = '{8'hCC, 8'hFF, 8'hFF, 8'h02, 3, 8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE};
    tbl[3] = '{8'hDD, 8'h00, 8'h00, 8'hF1, 1, 8'hFF, 8'hFF, 4'h1, 8'h00, 8'h00};
    tbl[4] = '{8'hCC, 8'h10, 8'h03, 8'h03, 0, 8'h10, 8'h03, 4'h3, 8'h05, 8'h00};
    tbl[5] = '{8'hCC, 8'h80, 8'h01, 8'h0E, 2, 8'h80, 8'h01, 4'hE, 8'h00, 8'h01};
    tbl[6] = '{8'hDD, 8'h00, 8'h00, 8'h0F, 0, 8'h80, 8'h01, 4'hF, 8'h00, 8'h00};
    tbl[7] = '{8'hCC, 8'h02, 8'h05, 8'h01, 0, 8'h02, 8'h05, 4'h1, 8'hFD, 8'hFF};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_outputs", 32'({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, RX_DROP, ERR}), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Vector table
    foreach (tbl[i]) begin
      e0 = en_cnt;
      r  = model_cmd(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].fb);
      do_cmd(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].fb, tbl[i].stall, 0, lo, hi);
      @(negedge CLK);
      chk($sformatf("vec%0d_lo", i), 32'(lo), 32'(tbl[i].lo));
      chk($sformatf("vec%0d_hi", i), 32'(hi), 32'(tbl[i].hi));
      chk($sformatf("vec%0d_a", i), 32'(ALU_A), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_b", i), 32'(ALU_B), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_fun", i), 32'(ALU_FUN), 32'(tbl[i].ef));
      chk($sformatf("vec%0d_en_pulses", i), 32'(en_cnt - e0), 32'd1);
      chk($sformatf("vec%0d_tx_idle", i), 32'(TX_VALID), 32'd0);
    end

    // Junk byte in IDLE is ignored without a drop pulse
    e0 = en_cnt;
    send(8'h55);
    chk("junk_no_drop", 32'(RX_DROP), 32'd0);
    repeat (3) @(negedge CLK);
    chk("junk_no_en", 32'(en_cnt - e0), 32'd0);

    // RX byte during TX_HI is dropped; the transfer completes unchanged
    r = model_cmd(8'hCC, 8'h05, 8'h03, 8'h00);
    send(8'hCC); send(8'h05); send(8'h03); send(8'h00);
    get_byte(0, lo);
    chk("drop_lo", 32'(lo), 32'h08);
    send(8'hDD);
    chk("drop_pulse", 32'(RX_DROP), 32'd1);
    chk("drop_tx_valid", 32'(TX_VALID), 32'd1);
    chk("drop_tx_data", 32'(TX_DATA), 32'h00);
    get_byte(0, hi);
    chk("drop_hi", 32'(hi), 32'h00);
    chk("drop_pulse_end", 32'(RX_DROP), 32'd0);
    r = model_cmd(8'hDD, 8'h00, 8'h00, 8'h01);
    do_cmd(8'hDD, 8'h00, 8'h00, 8'h01, 0, 0, lo, hi);
    chk("after_drop_res", 32'({hi, lo}), 32'(r));

    // ALU timeout: ERR after WAIT_MAX empty wait cycles, nothing transmitted
    mute = 1'b1;
    r = model_cmd(8'hCC, 8'h01, 8'h01, 8'h00);
    send(8'hCC); send(8'h01); send(8'h01); send(8'h00);
    n = 0;
    while (!ALU_EN && n < 5) begin
      @(negedge CLK);
      n++;
    end
    if (!ALU_EN) fail_to("timeout_en");
    err_at = -1; err_n = 0; tx_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (ERR) begin
        err_n++;
        if (err_at < 0) err_at = k;
      end
      if (TX_VALID) tx_seen++;
    end
    chk("err_cycle", 32'(err_at), 32'(WAIT_MAX + 1));
    chk("err_width", 32'(err_n), 32'd1);
    chk("err_no_tx", 32'(tx_seen), 32'd0);
    mute = 1'b0;
    r = model_cmd(8'hDD, 8'h00, 8'h00, 8'h00);
    do_cmd(8'hDD, 8'h00, 8'h00, 8'h00, 0, 0, lo, hi);
    chk("after_err_res", 32'({hi, lo}), 32'(r));

    // Reset during TX_HI clears all outputs at once; next command works
    r = model_cmd(8'hCC, 8'h12, 8'h34, 8'h02);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
    get_byte(0, lo);
    chk("rst_mid_valid_before", 32'(TX_VALID), 32'd1);
    #1 RST = 1'b0;
    #1 chk("rst_mid_outputs", 32'({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, RX_DROP, ERR}), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0;
    @(negedge CLK);
    r = model_cmd(8'hCC, 8'h07, 8'h06, 8'h02);
    do_cmd(8'hCC, 8'h07, 8'h06, 8'h02, 0, 0, lo, hi);
    chk("after_rst_res", 32'({hi, lo}), 32'(r));

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'hCC || c == 8'hDD) c = 8'h00;
        send(c);
      end
      c  = ($urandom_range(0, 1) != 0) ? 8'hCC : 8'hDD;
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      fb = 8'($urandom_range(0, 255));
      e0 = en_cnt;
      r  = model_cmd(c, a, b, fb);
      do_cmd(c, a, b, fb, $urandom_range(0, 3), $urandom_range(0, 3), lo, hi);
      @(negedge CLK);
      chk($sformatf("rnd%0d_res", i), 32'({hi, lo}), 32'(r));
      chk($sformatf("rnd%0d_regs", i), 32'({ALU_A, ALU_B, ALU_FUN}), 32'({m_a, m_b, m_fun}));
      chk($sformatf("rnd%0d_en", i), 32'(en_cnt - e0), 32'd1);
    end

    chk("en_single_cycle", 32'(en_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
